// File: rtl/q710.sv
// q710: vending-machine controller for five products.
// Credits money strobes on rising edges, takes an order on start, lets the
// order grow with add_more during a short window, then either dispenses and
// returns change or refunds everything. Returned money is broken into
// 100/50/20/10/5 denominations.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin an order (IDLE only)
//   money_{5,10,20,50,100}   money-insert strobes (edge-detected)
//   quantity_*               requested units per product
//   add_more                 add current quantities to the order (edge-detected)
//   dispense_*               units dispensed on a successful vend
//   change / refund          amount returned on success / failure
//   notes_*                  denomination counts of the returned amount
module q710 #(
  parameter int unsigned PRICE_COLD_DRINK         = 20,
  parameter int unsigned PRICE_DAIRY_MILK         = 10,
  parameter int unsigned PRICE_BISCUITS           = 5,
  parameter int unsigned PRICE_RED_BULL           = 50,
  parameter int unsigned PRICE_IMPORTED_CHOCOLATE = 25,
  parameter int unsigned MORE_WINDOW              = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        money_5,
  input  logic        money_10,
  input  logic        money_20,
  input  logic        money_50,
  input  logic        money_100,
  input  logic [3:0]  quantity_cold_drink,
  input  logic [3:0]  quantity_dairy_milk,
  input  logic [3:0]  quantity_biscuits,
  input  logic [3:0]  quantity_red_bull,
  input  logic [3:0]  quantity_imported_chocolate,
  input  logic        add_more,
  output logic [3:0]  dispense_cold_drink,
  output logic [3:0]  dispense_dairy_milk,
  output logic [3:0]  dispense_biscuits,
  output logic [3:0]  dispense_red_bull,
  output logic [3:0]  dispense_imported_chocolate,
  output logic [31:0] change,
  output logic [31:0] refund,
  output logic [31:0] notes_100,
  output logic [31:0] notes_50,
  output logic [31:0] notes_20,
  output logic [31:0] notes_10,
  output logic [31:0] notes_5
);

  localparam int unsigned NPROD = 5;
  localparam int unsigned QW    = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned CNTW  = $clog2(MORE_WINDOW + 1);

  localparam logic [AW-1:0] PRICE [NPROD] = '{
    AW'(PRICE_COLD_DRINK), AW'(PRICE_DAIRY_MILK), AW'(PRICE_BISCUITS),
    AW'(PRICE_RED_BULL),   AW'(PRICE_IMPORTED_CHOCOLATE)
  };

  typedef enum logic [1:0] {IDLE, SELECT, MORE, VEND} state_e;

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic [4:0]      money_prev_q;
  logic            add_prev_q;
  logic [QW-1:0]   ord_q  [NPROD];
  logic [QW-1:0]   disp_q [NPROD];
  logic [AW-1:0]   total_amount;
  logic [AW-1:0]   total_cost;

  logic [QW-1:0]   qty_c [NPROD];
  logic [QW-1:0]   sat_c [NPROD];
  logic [4:0]      money_vec_c;
  logic [4:0]      money_rise_c;
  logic [AW-1:0]   money_add_c;
  logic            add_rise_c;
  logic [AW-1:0]   sel_cost_c;
  logic [AW-1:0]   add_cost_c;
  logic            vend_ok_c;
  logic [AW-1:0]   ret_c;
  logic [AW-1:0]   r50_c, r20_c, r10_c, r5_c;

  assign qty_c[0] = quantity_cold_drink;
  assign qty_c[1] = quantity_dairy_milk;
  assign qty_c[2] = quantity_biscuits;
  assign qty_c[3] = quantity_red_bull;
  assign qty_c[4] = quantity_imported_chocolate;

  assign dispense_cold_drink         = disp_q[0];
  assign dispense_dairy_milk         = disp_q[1];
  assign dispense_biscuits           = disp_q[2];
  assign dispense_red_bull           = disp_q[3];
  assign dispense_imported_chocolate = disp_q[4];

  // Money credited this cycle: sum of denominations with a 0->1 edge.
  assign money_vec_c  = {money_100, money_50, money_20, money_10, money_5};
  assign money_rise_c = money_vec_c & ~money_prev_q;
  assign money_add_c  = (money_rise_c[0] ? AW'(5)   : '0)
                      + (money_rise_c[1] ? AW'(10)  : '0)
                      + (money_rise_c[2] ? AW'(20)  : '0)
                      + (money_rise_c[3] ? AW'(50)  : '0)
                      + (money_rise_c[4] ? AW'(100) : '0);

  assign add_rise_c = add_more & ~add_prev_q;
  assign cnt_d      = cnt_q + CNTW'(1);

  // Order cost at SELECT, and saturated order growth on an add_more edge.
  always_comb begin
    logic [QW:0] sum;
    sel_cost_c = '0;
    add_cost_c = '0;
    sum        = '0;
    for (int i = 0; i < NPROD; i++) begin
      sum        = (QW+1)'(ord_q[i]) + (QW+1)'(qty_c[i]);
      sat_c[i]   = sum[QW] ? {QW{1'b1}} : sum[QW-1:0];
      sel_cost_c = sel_cost_c + AW'(qty_c[i]) * PRICE[i];
      add_cost_c = add_cost_c + AW'(sat_c[i] - ord_q[i]) * PRICE[i];
    end
  end

  // Returned amount and its greedy denomination breakdown.
  assign vend_ok_c = total_amount >= total_cost;
  assign ret_c     = vend_ok_c ? (total_amount - total_cost) : total_amount;
  assign r50_c     = ret_c % AW'(100);
  assign r20_c     = r50_c % AW'(50);
  assign r10_c     = r20_c % AW'(20);
  assign r5_c      = r10_c % AW'(10);

  // Controller state, credit/cost registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      money_prev_q <= '0;
      add_prev_q   <= 1'b0;
      total_amount <= '0;
      total_cost   <= '0;
      change       <= '0;
      refund       <= '0;
      notes_100    <= '0;
      notes_50     <= '0;
      notes_20     <= '0;
      notes_10     <= '0;
      notes_5      <= '0;
      for (int i = 0; i < NPROD; i++) begin
        ord_q[i]  <= '0;
        disp_q[i] <= '0;
      end
    end else begin
      money_prev_q <= money_vec_c;
      add_prev_q   <= add_more;
      total_amount <= total_amount + money_add_c;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SELECT;
            change    <= '0;
            refund    <= '0;
            notes_100 <= '0;
            notes_50  <= '0;
            notes_20  <= '0;
            notes_10  <= '0;
            notes_5   <= '0;
            for (int i = 0; i < NPROD; i++) disp_q[i] <= '0;
          end
        end
        SELECT: begin
          for (int i = 0; i < NPROD; i++) ord_q[i] <= qty_c[i];
          total_cost <= sel_cost_c;
          cnt_q      <= '0;
          state_q    <= MORE;
        end
        MORE: begin
          if (add_rise_c) begin
            for (int i = 0; i < NPROD; i++) ord_q[i] <= sat_c[i];
            total_cost <= total_cost + add_cost_c;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNTW'(MORE_WINDOW)) state_q <= VEND;
          end
        end
        VEND: begin
          for (int i = 0; i < NPROD; i++) begin
            disp_q[i] <= vend_ok_c ? ord_q[i] : '0;
            ord_q[i]  <= '0;
          end
          change     <= vend_ok_c ? ret_c : '0;
          refund     <= vend_ok_c ? '0 : ret_c;
          notes_100  <= ret_c / AW'(100);
          notes_50   <= r50_c / AW'(50);
          notes_20   <= r20_c / AW'(20);
          notes_10   <= r10_c / AW'(10);
          notes_5    <= r5_c / AW'(5);
          total_cost <= '0;
          // Money arriving during the vend cycle credits the next order.
          total_amount <= money_add_c;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q710.sv
// Bench for q710: scenario tasks with a scoreboard of expected vend results.
module tb_q710;

  localparam int unsigned W = 4;
  localparam int unsigned PRICE [5] = '{20, 10, 5, 50, 25};
  localparam int unsigned DENOM [5] = '{100, 50, 20, 10, 5};

  typedef struct packed {
    logic [4:0][3:0]  d;
    logic [31:0]      chg;
    logic [31:0]      rfd;
    logic [4:0][31:0] n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, add_more;
  logic        m5, m10, m20, m50, m100;
  logic [3:0]  qty  [5];
  logic [3:0]  disp [5];
  logic [31:0] change, refund;
  logic [31:0] notes [5];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned m_amount = 0;
  exp_t        sb [$];

  always #5 clk = ~clk;

  q710 dut (
    .clk(clk), .rst(rst), .start(start),
    .money_5(m5), .money_10(m10), .money_20(m20), .money_50(m50), .money_100(m100),
    .quantity_cold_drink(qty[0]), .quantity_dairy_milk(qty[1]),
    .quantity_biscuits(qty[2]), .quantity_red_bull(qty[3]),
    .quantity_imported_chocolate(qty[4]),
    .add_more(add_more),
    .dispense_cold_drink(disp[0]), .dispense_dairy_milk(disp[1]),
    .dispense_biscuits(disp[2]), .dispense_red_bull(disp[3]),
    .dispense_imported_chocolate(disp[4]),
    .change(change), .refund(refund),
    .notes_100(notes[0]), .notes_50(notes[1]), .notes_20(notes[2]),
    .notes_10(notes[3]), .notes_5(notes[4])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_qty(input logic [4:0][3:0] q);
    for (int i = 0; i < 5; i++) qty[i] = q[i];
  endtask

  task automatic insert(input int unsigned val);
    case (val)
      5:   m5   = 1'b1;
      10:  m10  = 1'b1;
      20:  m20  = 1'b1;
      50:  m50  = 1'b1;
      default: m100 = 1'b1;
    endcase
    tick();
    {m5, m10, m20, m50, m100} = '0;
    tick();
    m_amount += val;
  endtask

  function automatic exp_t model(input int unsigned amt, input int unsigned cost,
                                 input logic [4:0][3:0] ord);
    exp_t e;
    int unsigned ret;
    e = '0;
    if (amt >= cost) begin
      e.d   = ord;
      e.chg = amt - cost;
      ret   = amt - cost;
    end else begin
      e.rfd = amt;
      ret   = amt;
    end
    for (int i = 0; i < 5; i++) begin
      e.n[i] = ret / DENOM[i];
      ret    = ret % DENOM[i];
    end
    return e;
  endfunction

  // Drives one full order and checks timing, cost and the vend result.
  task automatic run_order(input string name, input logic [4:0][3:0] sel,
                           input bit do_add, input logic [4:0][3:0] add,
                           input bit m5_in_vend, output int unsigned cost_o);
    int unsigned     sel_cost, cost, nq;
    logic [4:0][3:0] ord;
    exp_t            e, got;
    ord = sel;
    sel_cost = 0;
    for (int i = 0; i < 5; i++) sel_cost += int'(sel[i]) * PRICE[i];
    cost = sel_cost;
    if (do_add) begin
      for (int i = 0; i < 5; i++) begin
        nq = int'(ord[i]) + int'(add[i]);
        if (nq > 15) nq = 15;
        cost += (nq - int'(ord[i])) * PRICE[i];
        ord[i] = 4'(nq);
      end
    end
    cost_o = cost;
    sb.push_back(model(m_amount, cost, ord));

    start = 1'b1;
    set_qty(sel);
    tick();
    start = 1'b0;
    tick();
    set_qty('0);
    total++;
    if (dut.total_cost !== 32'(sel_cost)) begin
      bad++;
      $display("FAIL %s select_cost: got %0d want %0d", name, dut.total_cost, sel_cost);
    end
    if (do_add) begin
      add_more = 1'b1;
      set_qty(add);
      tick();
      add_more = 1'b0;
      set_qty('0);
    end
    repeat (W) tick();
    total++;
    if (change !== 0 || refund !== 0 || disp[0] !== 0 || disp[1] !== 0 || disp[2] !== 0 ||
        disp[3] !== 0 || disp[4] !== 0 || dut.total_cost !== 32'(cost)) begin
      bad++;
      $display("FAIL %s pre_vend: change=%0d refund=%0d cost=%0d want 0/0/%0d",
               name, change, refund, dut.total_cost, cost);
    end
    if (m5_in_vend) m5 = 1'b1;
    tick();
    m5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got.d[i] = disp[i];
      got.n[i] = notes[i];
    end
    got.chg = change;
    got.rfd = refund;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard: got empty queue want one entry", name);
    end else begin
      e = sb.pop_front();
      if (got.d !== e.d) begin
        bad++;
        $display("FAIL %s dispense: got %h want %h", name, got.d, e.d);
      end
      total++;
      if (got.chg !== e.chg) begin
        bad++;
        $display("FAIL %s change: got %0d want %0d", name, got.chg, e.chg);
      end
      total++;
      if (got.rfd !== e.rfd) begin
        bad++;
        $display("FAIL %s refund: got %0d want %0d", name, got.rfd, e.rfd);
      end
      total++;
      if (got.n !== e.n) begin
        bad++;
        $display("FAIL %s notes: got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d", name,
                 got.n[0], got.n[1], got.n[2], got.n[3], got.n[4],
                 e.n[0], e.n[1], e.n[2], e.n[3], e.n[4]);
      end
    end
    m_amount = m5_in_vend ? 5 : 0;
    total++;
    if (dut.total_amount !== 32'(m_amount) || dut.total_cost !== 0) begin
      bad++;
      $display("FAIL %s post_vend_regs: amount=%0d cost=%0d want %0d/0",
               name, dut.total_amount, dut.total_cost, m_amount);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (change !== 0 || refund !== 0 || notes[0] !== 0 || notes[1] !== 0 || notes[2] !== 0 ||
        notes[3] !== 0 || notes[4] !== 0 || disp[0] !== 0 || disp[1] !== 0 ||
        disp[2] !== 0 || disp[3] !== 0 || disp[4] !== 0 ||
        dut.total_amount !== 0 || dut.total_cost !== 0) begin
      bad++;
      $display("FAIL reset: change=%0d refund=%0d amount=%0d cost=%0d want all 0",
               change, refund, dut.total_amount, dut.total_cost);
    end
    rst = 1'b0;
    m_amount = 0;
    tick();
  endtask

  task automatic test_change_add_more();
    int unsigned c;
    insert(100);
    run_order("change_add", 20'h00010, 1'b1, 20'h10001, 1'b0, c);
    total++;
    if (c != 55 || change !== 45 || notes[2] !== 2 || notes[4] !== 1) begin
      bad++;
      $display("FAIL change_add_fixed: cost=%0d change=%0d n20=%0d n5=%0d want 55/45/2/1",
               c, change, notes[2], notes[4]);
    end
  endtask

  task automatic test_exact_choc();
    int unsigned c;
    insert(50);
    run_order("exact_choc", 20'h20000, 1'b0, '0, 1'b0, c);
    total++;
    if (change !== 0 || disp[4] !== 2) begin
      bad++;
      $display("FAIL exact_choc_fixed: change=%0d choc=%0d want 0/2", change, disp[4]);
    end
  endtask

  task automatic test_exact_mixed();
    int unsigned c;
    insert(50);
    run_order("exact_mixed", 20'h00202, 1'b0, '0, 1'b0, c);
    total++;
    if (c != 50 || change !== 0 || disp[0] !== 2 || disp[2] !== 2) begin
      bad++;
      $display("FAIL exact_mixed_fixed: change=%0d cold=%0d bisc=%0d want 0/2/2",
               change, disp[0], disp[2]);
    end
  endtask

  task automatic test_insufficient();
    int unsigned c;
    insert(20);
    run_order("insufficient", 20'h01000, 1'b0, '0, 1'b0, c);
    total++;
    if (refund !== 20 || notes[2] !== 1 || change !== 0 || disp[3] !== 0) begin
      bad++;
      $display("FAIL insufficient_fixed: refund=%0d n20=%0d change=%0d want 20/1/0",
               refund, notes[2], change);
    end
  endtask

  task automatic test_saturation();
    int unsigned c;
    insert(100);
    run_order("saturation", 20'h00A00, 1'b1, 20'h00A00, 1'b0, c);
    total++;
    if (c != 75 || disp[2] !== 15 || change !== 25) begin
      bad++;
      $display("FAIL saturation_fixed: bisc=%0d change=%0d want 15/25", disp[2], change);
    end
  endtask

  task automatic test_money_edges();
    int unsigned c;
    m100 = 1'b1;
    repeat (3) tick();
    m100 = 1'b0;
    tick();
    m_amount = 100;
    total++;
    if (dut.total_amount !== 100) begin
      bad++;
      $display("FAIL money_held: got %0d want 100", dut.total_amount);
    end
    m50 = 1'b1;
    m10 = 1'b1;
    tick();
    m50 = 1'b0;
    m10 = 1'b0;
    tick();
    m_amount = 160;
    total++;
    if (dut.total_amount !== 160) begin
      bad++;
      $display("FAIL money_same_cycle: got %0d want 160", dut.total_amount);
    end
    // Empty order: success with zero dispense, money_5 during vend carries over.
    run_order("zero_cost", '0, 1'b0, '0, 1'b1, c);
    tick();
    total++;
    if (dut.total_amount !== 5 || change !== 160) begin
      bad++;
      $display("FAIL money_vend_carry: amount=%0d change=%0d want 5/160",
               dut.total_amount, change);
    end
  endtask

  task automatic test_reset_mid_order();
    insert(50);
    start = 1'b1;
    qty[3] = 4'd1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    qty[3] = 4'd0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    m_amount = 0;
    repeat (W + 3) tick();
    total++;
    if (refund !== 0 || change !== 0 || disp[3] !== 0 ||
        dut.total_amount !== 0 || dut.total_cost !== 0) begin
      bad++;
      $display("FAIL reset_mid: refund=%0d change=%0d amount=%0d want 0",
               refund, change, dut.total_amount);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned c;
    insert(20);
    run_order("b2b_first", 20'h00020, 1'b0, '0, 1'b0, c);
    insert(10);
    insert(5);
    run_order("b2b_second", 20'h00101, 1'b0, '0, 1'b0, c);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    add_more = 1'b0;
    {m5, m10, m20, m50, m100} = '0;
    for (int i = 0; i < 5; i++) qty[i] = '0;
    test_reset();
    test_change_add_more();
    test_exact_choc();
    test_exact_mixed();
    test_insufficient();
    test_saturation();
    test_money_edges();
    test_reset_mid_order();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
